// File: rtl/fir_coef_ctrl.sv
// Double-buffered FIR coefficient controller: writes land in a shadow bank, a commit
// drains the filter pipeline (sample strobe masked) and then swaps shadow into active.
// Optional shadow readback port when FIR_COEF_READBACK_EN is defined.
module fir_coef_ctrl #(
  parameter int CW        = 12,
  parameter int NCOE      = 8,
  parameter int DRAIN_CYC = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [2:0]         wr_addr_i,
  input  logic [CW-1:0]      wr_data_i,
  input  logic               commit_req_i,
  output logic               commit_ack_o,
  input  logic               en_i,
  output logic               en_out_o,
  output logic               busy_o,
  output logic [NCOE*CW-1:0] coe_flat_o,
  output logic [7:0]         drop_cnt_o
`ifdef FIR_COEF_READBACK_EN
  ,
  input  logic [2:0]         rd_addr_i,
  output logic [CW-1:0]      rd_data_o
`endif
);

  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

  localparam int         DEF_COE [8] = '{11, 31, 63, 104, 152, 198, 235, 255};
  localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYC);

  state_t                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       ack_q, ack_d;
  logic                       swap;
  logic [7:0]                 drop_q;
  logic [NCOE-1:0][CW-1:0]    shadow_q;
  logic [NCOE-1:0][CW-1:0]    active_q;
  logic                       busy;
  logic                       wr_fire;

  assign busy         = (state_q != IDLE);
  assign wr_ready_o   = ~busy;
  assign wr_fire      = wr_valid_i & ~busy;
  assign busy_o       = busy;
  assign en_out_o     = en_i & ~busy;
  assign commit_ack_o = ack_q;
  assign coe_flat_o   = active_q;
  assign drop_cnt_o   = drop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    swap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (commit_req_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == DRAIN_LAST) begin
          state_d = SWAP;
          cnt_d   = '0;
        end
      end
      SWAP: begin
        state_d = IDLE;
        swap    = 1'b1;
        ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  // Shadow is frozen while busy (wr_ready low), so the swap copies a stable bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCOE; k++) begin
        shadow_q[k] <= CW'(DEF_COE[k % 8]);
        active_q[k] <= CW'(DEF_COE[k % 8]);
      end
    end else begin
      if (wr_fire && (32'(wr_addr_i) < NCOE))
        shadow_q[wr_addr_i] <= wr_data_i;
      if (swap)
        active_q <= shadow_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      drop_q <= '0;
    else if (en_i && busy && (drop_q != 8'hFF))
      drop_q <= drop_q + 8'd1;
  end

`ifdef FIR_COEF_READBACK_EN
  logic [CW-1:0] rd_data_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      rd_data_q <= '0;
    else
      rd_data_q <= shadow_q[rd_addr_i];
  end
  assign rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Randomized bench for fir_coef_ctrl against a commit-window reference model
// (busy window, ack cycle and swap derived from the commit cycle number).
module tb_fir_coef_ctrl;
  localparam int CW   = 12;
  localparam int NCOE = 8;
  localparam int D    = 8;
  localparam int DEF [8] = '{11, 31, 63, 104, 152, 198, 235, 255};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_valid = 1'b0;
  logic               wr_ready;
  logic [2:0]         wr_addr = '0;
  logic [CW-1:0]      wr_data = '0;
  logic               commit_req = 1'b0;
  logic               commit_ack;
  logic               en = 1'b0;
  logic               en_out;
  logic               busy;
  logic [NCOE*CW-1:0] coe_flat;
  logic [7:0]         drop_cnt;
`ifdef FIR_COEF_READBACK_EN
  logic [2:0]         rd_addr = '0;
  logic [CW-1:0]      rd_data;
`endif

  always #5 clk = ~clk;

  fir_coef_ctrl #(.CW(CW), .NCOE(NCOE), .DRAIN_CYC(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .commit_req_i(commit_req), .commit_ack_o(commit_ack),
    .en_i(en), .en_out_o(en_out), .busy_o(busy),
    .coe_flat_o(coe_flat), .drop_cnt_o(drop_cnt)
`ifdef FIR_COEF_READBACK_EN
    , .rd_addr_i(rd_addr), .rd_data_o(rd_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: banks as arrays, commit tracked as a cycle window.
  logic [CW-1:0] sh_m  [NCOE];
  logic [CW-1:0] act_m [NCOE];
  logic [CW-1:0] rd_m;
  int cyc = 0, busy_lo, busy_hi, ack_at, drop_m;

  function automatic logic [NCOE*CW-1:0] flat();
    logic [NCOE*CW-1:0] f;
    for (int k = 0; k < NCOE; k++) f[k*CW +: CW] = act_m[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCOE; k++) begin
      sh_m[k]  = CW'(DEF[k]);
      act_m[k] = CW'(DEF[k]);
    end
    busy_lo = 1; busy_hi = 0; ack_at = -1; drop_m = 0; rd_m = '0;
  endtask

  task automatic step(input bit wv, input int wa, input int wd, input bit cr, input bit e);
    bit bsy;
    int ra;
    @(negedge clk);
    wr_valid = wv; wr_addr = wa[2:0]; wr_data = wd[CW-1:0];
    commit_req = cr; en = e;
    ra = $urandom_range(0, 7);
`ifdef FIR_COEF_READBACK_EN
    rd_addr = ra[2:0];
`endif
    #1;
    bsy = (cyc >= busy_lo) && (cyc <= busy_hi);
    chk("busy", busy, bsy);
    chk("wr_ready", wr_ready, !bsy);
    chk("en_out", en_out, e && !bsy);
    chk("commit_ack", commit_ack, cyc == ack_at);
    chk("coe_flat", coe_flat, flat());
    chk("drop_cnt", drop_cnt, drop_m);
`ifdef FIR_COEF_READBACK_EN
    chk("rd_data", rd_data, rd_m);
`endif
    @(posedge clk);
    rd_m = sh_m[ra];
    if (e && bsy && drop_m < 255) drop_m++;
    if (bsy && cyc == busy_hi) for (int k = 0; k < NCOE; k++) act_m[k] = sh_m[k];
    if (wv && !bsy) sh_m[wa] = wd[CW-1:0];
    if (cr && !bsy) begin
      busy_lo = cyc + 1; busy_hi = cyc + D + 1; ack_at = cyc + D + 2;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b0; commit_req = 1'b0; en = 1'b0;
    model_reset();
    #1;
    chk("rst_ack", commit_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_coe", coe_flat, flat());
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step(0, 0, 0, 0, 0);

    // write addr3=500, commit, coe unchanged until ack
    step(1, 3, 500, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (D) step(0, 0, 0, 0, 0);
    chk("coe3_before", coe_flat[3*CW +: CW], 104);
    repeat (2) step(0, 0, 0, 0, 0);
    #1 chk("coe3_after", coe_flat[3*CW +: CW], 500);

    // en held through commits: 9 drops each, saturating at 255
    for (int n = 0; n < 29; n++) begin
      step(0, 0, 0, 1, 1);
      repeat (D + 1) step(0, 0, 0, 0, 1);
      if (n == 0) begin
        #1 chk("drop_one", drop_cnt, 9);
      end
    end
    step(0, 0, 0, 0, 0);
    chk("drop_sat", drop_cnt, 255);

    // write and commit in the same cycle; writes during drain held off
    step(1, 0, 7, 1, 0);
    repeat (D + 1) step(1, 2, 99, 0, 0);
    step(1, 2, 99, 0, 0);
    chk("coe0_same", coe_flat[0 +: CW], 7);
    chk("coe2_held", coe_flat[2*CW +: CW], 63);

    // reset mid-commit aborts it
    step(1, 6, 1234, 0, 0);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    do_reset();
    repeat (D + 3) step(0, 0, 0, 0, 0);
    chk("coe6_abort", coe_flat[6*CW +: CW], 235);
    step(1, 6, 1234, 1, 0);
    repeat (D + 2) step(0, 0, 0, 0, 0);
    chk("coe6_recommit", coe_flat[6*CW +: CW], 1234);

    // randomized traffic
    repeat (1500) begin
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 4095),
           $urandom_range(0, 11) == 0, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_coef_ctrl.md
FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

Interface
REQ-001 The block SHALL have parameter CW, default 12, giving the coefficient width in bits.
REQ-002 The block SHALL have parameter NCOE, default 8, giving the number of symmetric coefficients; the address width is fixed at 3 bits.
REQ-003 The block SHALL have parameter DRAIN_CYC, default 8, range 1..255, giving the number of cycles the filter pipeline is drained before a swap.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wr_valid  in  1  coefficient write request.
REQ-007 wr_ready  out  1  write accepted when wr_valid&wr_ready.
REQ-008 wr_addr  in  3  shadow coefficient index.
REQ-009 wr_data  in  CW  unsigned coefficient value.
REQ-010 commit_req  in  1  request to copy shadow bank to active bank.
REQ-011 commit_ack  out  1  one-cycle pulse: active bank updated.
REQ-012 en  in  1  sample strobe from source.
REQ-013 en_out  out  1  gated sample strobe to filter.
REQ-014 busy  out  1  commit in progress.
REQ-015 coe_flat  out  NCOE*CW  active bank; coe[k] at bits [CW*k+CW-1 : CW*k].
REQ-016 drop_cnt  out  8  saturating count of samples masked during commits.

Function
REQ-017 Writes SHALL update only the shadow bank, one cycle after handshake.
REQ-018 wr_ready SHALL be 1 in IDLE and 0 in DRAIN and SWAP.
REQ-019 The FSM SHALL have states IDLE, DRAIN, SWAP: IDLE->DRAIN on commit_req; DRAIN->SWAP when the drain counter reaches DRAIN_CYC; SWAP->IDLE unconditionally.
REQ-020 commit_req SHALL be sampled only in IDLE; assertions in DRAIN or SWAP SHALL be ignored and not queued.
REQ-021 On commit_req at cycle t, busy SHALL be 1 for cycles t+1..t+DRAIN_CYC+1, the active bank SHALL load the shadow bank at the end of cycle t+DRAIN_CYC+1, and commit_ack and the new coe_flat SHALL appear at cycle t+DRAIN_CYC+2.
REQ-022 en_out SHALL equal en & ~busy (combinational); en at cycle t itself passes.
REQ-023 Each cycle with en=1 and busy=1 SHALL increment drop_cnt, saturating at 255.
REQ-024 If wr_valid and commit_req are both asserted in the same IDLE cycle, the write SHALL be accepted and included in that commit.
REQ-025 coe_flat SHALL never change except in the SWAP->IDLE transition.
REQ-026 A commit with no prior writes SHALL still run the full sequence and pulse commit_ack.

Reset
REQ-027 On rst, both banks SHALL load coefficient indices 0..7 with 11, 31, 63, 104, 152, 198, 235, 255.
REQ-028 On rst, the FSM SHALL go to IDLE, and busy, commit_ack, drop_cnt and the drain counter SHALL be 0.
REQ-029 A reset during DRAIN or SWAP SHALL abort the commit with no commit_ack, leaving the default coefficients active.

Configuration
REQ-030 With macro FIR_COEF_READBACK_EN defined, the block SHALL add ports rd_addr (in, 3) and rd_data (out, CW), where rd_data is the shadow entry at rd_addr, registered with 1-cycle latency and reset to 0.
REQ-031 Without FIR_COEF_READBACK_EN, the block SHALL have no rd_addr or rd_data ports, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Release reset -> coe_flat coefficients 0..7 = 11, 31, 63, 104, 152, 198, 235, 255; wr_ready=1; drop_cnt=0.
REQ-033 Write addr3=500 and pulse commit_req at t with DRAIN_CYC=8 -> busy during t+1..t+9, commit_ack at t+10, coe[3]=500; coe_flat unchanged before t+10.
REQ-034 Hold en=1 continuously through a commit -> en_out=0 for 9 cycles and drop_cnt=9; after 29 such commits drop_cnt=255 (saturated).
REQ-035 Assert wr_valid and commit_req in the same cycle (addr0=7) -> the commit applies coe[0]=7; wr_valid held during DRAIN is not accepted until IDLE.
REQ-036 Assert rst at t+4 mid-commit -> no commit_ack, defaults active, and a following commit_req is handled normally.
REQ-037 With FIR_COEF_READBACK_EN, write addr5=77 then rd_addr=5 -> rd_data=77 one cycle later, while coe[5] stays 198 until commit.
